// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester-side and FIFO-write-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface fifo_wr_arbiter_if #(
    parameter int B = 8,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*B-1:0] req_data;
    logic           fifo_full;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [IW-1:0]  cur_owner;

    modport master (
        output req, req_data, fifo_full,
        input  fifo_wr, fifo_w_data, gnt, busy, cur_owner
    );

    modport slave (
        input  req, req_data, fifo_full,
        output fifo_wr, fifo_w_data, gnt, busy, cur_owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Bursts of up to BURST words per grant; hand-offs happen without a bubble.
module fifo_wr_arbiter #(
    parameter int B     = 8,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input logic               clk,
    input logic               reset,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;

    logic          owner_req;
    logic          write_ok;
    logic          burst_end;
    logic          release_now;
    logic [N-1:0]  rel_req;
    logic [IW:0]   idle_pick;
    logic [IW:0]   rel_pick;

    // Scan base+1, base+2, ... wrapping, ending at base itself; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [IW-1:0] base, input logic [N-1:0] r);
        logic          found;
        logic [IW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(base) + i) % N;
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        return {found, idx};
    endfunction

    assign owner_req   = bus.req[owner];
    assign write_ok    = (state == GRANT) && owner_req && !bus.fifo_full;
    assign burst_end   = (cnt == CW'(BURST - 1));
    assign release_now = (state == GRANT) && (!owner_req || (write_ok && burst_end));
    // An owner that dropped req must not win its own re-arbitration.
    assign rel_req     = owner_req ? bus.req : (bus.req & ~(N'(1) << owner));
    assign idle_pick   = rr_pick(last, bus.req);
    assign rel_pick    = rr_pick(owner, rel_req);

    assign bus.fifo_wr     = write_ok && !reset;
    assign bus.gnt         = bus.fifo_wr ? (N'(1) << owner) : '0;
    assign bus.fifo_w_data = bus.fifo_wr ? bus.req_data[int'(owner)*B +: B] : '0;
    assign bus.busy        = (state == GRANT) && !reset;
    assign bus.cur_owner   = reset ? '0 : owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(N - 1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[IW]) begin
                        owner <= idle_pick[IW-1:0];
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last <= owner;
                        if (rel_pick[IW]) begin
                            owner <= rel_pick[IW-1:0];
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (write_ok) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, BURST=4): every cycle's outputs
// are compared against hand-derived values with immediate assertions.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    logic [7:0] dval [4];

    fifo_wr_arbiter_if #(.B(8), .N(4)) bus ();

    fifo_wr_arbiter #(.B(8), .N(4), .BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic full);
        @(posedge clk);
        #1;
        reset         = r;
        bus.req       = rq;
        bus.fifo_full = full;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic ewr, input logic [3:0] egnt,
                               input logic [7:0] edata, input logic ebusy,
                               input logic chk_owner, input logic [1:0] eowner);
        logic [13:0] obs;
        logic [13:0] expv;
        obs  = {bus.fifo_wr, bus.gnt, bus.fifo_w_data, bus.busy};
        expv = {ewr, egnt, edata, ebusy};
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: wr/gnt/data/busy got %b/%b/%h/%b want %b/%b/%h/%b",
                   tag, obs[13], obs[12:9], obs[8:1], obs[0],
                   expv[13], expv[12:9], expv[8:1], expv[0]);
        end
        if (chk_owner) begin
            compared++;
            assert (bus.cur_owner === eowner) else begin
                mismatched++;
                $error("[TB] FAIL %s_owner: cur_owner got %0d want %0d", tag, bus.cur_owner, eowner);
            end
        end
    endtask

    task automatic expectWrite(input string tag, input int k);
        checkOutput(tag, 1'b1, 4'(1 << k), dval[k], 1'b1, 1'b1, 2'(k));
    endtask

    task automatic expectHold(input string tag, input int k);
        checkOutput(tag, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b1, 2'(k));
    endtask

    task automatic expectIdle(input string tag);
        checkOutput(tag, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic expectReset(input string tag);
        checkOutput(tag, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        dval[0]       = 8'hA5;
        dval[1]       = 8'hB1;
        dval[2]       = 8'hC2;
        dval[3]       = 8'hD3;
        reset         = 1'b1;
        bus.req       = 4'b0000;
        bus.fifo_full = 1'b0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};

        applyStimulus(1'b1, 4'b0001, 1'b0); expectReset("rst_init0");
        applyStimulus(1'b1, 4'b0001, 1'b0); expectReset("rst_init1");

        // Lone requester: one arbitration cycle, then unbroken writes across bursts.
        applyStimulus(1'b0, 4'b0001, 1'b0); expectIdle("t1_arb");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 4'b0001, 1'b0); expectWrite($sformatf("t1_wr%0d", i), 0);
        end
        applyStimulus(1'b1, 4'b0001, 1'b0); expectReset("t1_rst_in_grant");

        // Everyone requesting: four-word bursts rotating 0,1,2,3,0.
        applyStimulus(1'b0, 4'b1111, 1'b0); expectIdle("t2_arb");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0); expectWrite($sformatf("t2_wr%0d", i), (i / 4) % 4);
        end
        applyStimulus(1'b1, 4'b1111, 1'b0); expectReset("t2_rst");

        // Full stall after two words; the held count leaves exactly two more for owner 0.
        applyStimulus(1'b0, 4'b0011, 1'b0); expectIdle("t3_arb");
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_wr0", 0);
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_wr1", 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1); expectHold($sformatf("t3_stall%0d", i), 0);
        end
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_wr2", 0);
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_wr3", 0);
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_next0", 1);
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t3_next1", 1);
        applyStimulus(1'b1, 4'b0011, 1'b0); expectReset("t3_rst");

        // Early drop by requester 0, then requester 1 drops and the arbiter idles.
        applyStimulus(1'b0, 4'b0011, 1'b0); expectIdle("t4_arb");
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t4_wr0", 0);
        applyStimulus(1'b0, 4'b0011, 1'b0); expectWrite("t4_wr1", 0);
        applyStimulus(1'b0, 4'b0010, 1'b0); expectHold("t4_drop0", 0);
        applyStimulus(1'b0, 4'b0010, 1'b0); expectWrite("t4_own1_0", 1);
        applyStimulus(1'b0, 4'b0010, 1'b0); expectWrite("t4_own1_1", 1);
        applyStimulus(1'b0, 4'b0000, 1'b0); expectHold("t4_drop1", 1);
        applyStimulus(1'b0, 4'b0000, 1'b0); expectIdle("t4_idle0");
        applyStimulus(1'b0, 4'b0000, 1'b0); expectIdle("t4_idle1");

        // Fairness: last owner was 1, so 3 wins before 1.
        applyStimulus(1'b0, 4'b1010, 1'b0); expectIdle("t5_arb");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1010, 1'b0); expectWrite($sformatf("t5_own3_%0d", i), 3);
        end
        applyStimulus(1'b0, 4'b1010, 1'b0); expectWrite("t5_own1_0", 1);
        applyStimulus(1'b0, 4'b1010, 1'b0); expectWrite("t5_own1_1", 1);

        // Reset during owner 2's third word: the partial burst is forgotten.
        applyStimulus(1'b1, 4'b1100, 1'b0); expectReset("t6_rst_pre");
        applyStimulus(1'b0, 4'b1100, 1'b0); expectIdle("t6_arb");
        applyStimulus(1'b0, 4'b1100, 1'b0); expectWrite("t6_wr0", 2);
        applyStimulus(1'b0, 4'b1100, 1'b0); expectWrite("t6_wr1", 2);
        applyStimulus(1'b1, 4'b1100, 1'b0); expectReset("t6_rst_mid");
        applyStimulus(1'b0, 4'b1100, 1'b0); expectIdle("t6_rearb");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1100, 1'b0); expectWrite($sformatf("t6_again%0d", i), 2);
        end
        applyStimulus(1'b0, 4'b1100, 1'b0); expectWrite("t6_own3", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
